// File: rtl/flac_pkg.sv
// flac_pkg: channel-assignment codes and decorrelator FSM states shared by the stereo path.
package flac_pkg;
    localparam logic [3:0] CH_INDEP_MONO   = 4'b0000;
    localparam logic [3:0] CH_INDEP_STEREO = 4'b0001;
    localparam logic [3:0] CH_LEFT_SIDE    = 4'b1000;
    localparam logic [3:0] CH_SIDE_RIGHT   = 4'b1001;
    localparam logic [3:0] CH_MID_SIDE     = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERROR} state_t;

    function automatic logic chan_supported(input logic [3:0] ca);
        return ca inside {CH_INDEP_MONO, CH_INDEP_STEREO, CH_LEFT_SIDE, CH_SIDE_RIGHT, CH_MID_SIDE};
    endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: show-ahead synchronous FIFO with flush, absorbs skew between channel decoders.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iFlush,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oEmpty,
    output logic             oFull
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign oEmpty = wr_ptr == rd_ptr;
    assign oFull  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign oData  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge iClock or negedge iReset_n)
        if (!iReset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (iFlush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (iPush && !oFull) wr_ptr <= wr_ptr + 1'b1;
            if (iPop && !oEmpty) rd_ptr <= rd_ptr + 1'b1;
        end
    always_ff @(posedge iClock)
        if (iPush && !oFull && !iFlush) mem[wr_ptr[AW-1:0]] <= iData;
endmodule

// File: rtl/stereo_decorrelator.sv
// stereo_decorrelator: merges two subframe streams and undoes FLAC inter-channel decorrelation.
module stereo_decorrelator
    import flac_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic [3:0]        iChanAssign,
    input  logic [15:0]       iBlockSize,
    input  logic              iValid0,
    input  logic [DATA_W-1:0] iSample0,
    output logic              oReady0,
    input  logic              iValid1,
    input  logic [DATA_W:0]   iSample1,
    output logic              oReady1,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oLeft,
    output logic [DATA_W-1:0] oRight,
    output logic              oFrameDone,
    output logic              oError
);
    state_t state, state_nxt;
    logic [3:0] chan;
    logic [15:0] blk_last, count;
    logic [DATA_W-1:0] d0;
    logic [DATA_W:0] d1;
    logic e0, f0, e1, f1;
    logic mono, run, accept, last, pop, overflow;
    logic signed [DATA_W+1:0] a, b, m, l, r;

    assign mono     = chan == CH_INDEP_MONO;
    assign run      = state == S_RUN;
    assign oReady0  = run & !f0;
    assign oReady1  = run & !mono & !f1;
    assign accept   = oValid & iReady;
    assign last     = accept & run & (count == blk_last);
    assign oFrameDone = last;
    // the final accept must not pull a pair beyond the block into the output register
    assign pop      = run & !iStart & !last & !e0 & (mono | !e1) & (!oValid | iReady);
    assign overflow = run & ((iValid0 & f0) | (!mono & iValid1 & f1));

    sample_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .iClock(iClock), .iReset_n(iReset_n), .iFlush(iStart), .iPush(iValid0 & oReady0),
        .iData(iSample0), .iPop(pop), .oData(d0), .oEmpty(e0), .oFull(f0)
    );
    sample_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .iClock(iClock), .iReset_n(iReset_n), .iFlush(iStart), .iPush(iValid1 & oReady1),
        .iData(iSample1), .iPop(pop & !mono), .oData(d1), .oEmpty(e1), .oFull(f1)
    );

    always_comb begin
        a = {{2{d0[DATA_W-1]}}, d0};
        b = {d1[DATA_W], d1};
        m = {a[DATA_W:0], b[0]};
        l = (chan == CH_SIDE_RIGHT) ? a + b : (chan == CH_MID_SIDE) ? (m + b) >>> 1 : a;
        r = mono ? a : (chan == CH_LEFT_SIDE) ? a - b : (chan == CH_MID_SIDE) ? (m - b) >>> 1 : b;
    end

    always_ff @(posedge iClock or negedge iReset_n)
        if (!iReset_n) state <= S_IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (iStart) state_nxt = chan_supported(iChanAssign) ? S_RUN : S_ERROR;
        else if (last) state_nxt = S_IDLE;
    end

    always_ff @(posedge iClock or negedge iReset_n)
        if (!iReset_n) begin
            chan     <= '0;
            blk_last <= '0;
            count    <= '0;
            oValid   <= 1'b0;
            oLeft    <= '0;
            oRight   <= '0;
            oError   <= 1'b0;
        end else if (iStart) begin
            chan     <= iChanAssign;
            blk_last <= (iBlockSize == 16'd0) ? 16'd0 : iBlockSize - 16'd1;
            count    <= '0;
            oValid   <= 1'b0;
            oError   <= !chan_supported(iChanAssign);
        end else begin
            if (overflow) oError <= 1'b1;
            if (accept) count <= last ? 16'd0 : count + 16'd1;
            if (pop) begin
                oValid <= 1'b1;
                oLeft  <= DATA_W'(l);
                oRight <= DATA_W'(r);
            end else if (accept) oValid <= 1'b0;
        end
endmodule

// File: tb/tb_stereo_decorrelator.sv
// tb_stereo_decorrelator: random and directed frames checked against an arithmetic model of the decorrelation.
module tb_stereo_decorrelator;
    localparam int W = 16;
    localparam int NOSTALL = 1 << 30;
    logic iClock = 0, iReset_n = 0, iStart = 0;
    logic [3:0] iChanAssign = 0;
    logic [15:0] iBlockSize = 0;
    logic iValid0 = 0, iValid1 = 0, iReady = 0;
    logic [W-1:0] iSample0 = 0;
    logic [W:0] iSample1 = 0;
    logic oReady0, oReady1, oValid, oFrameDone, oError;
    logic [W-1:0] oLeft, oRight;
    int n_cmp = 0, n_err = 0;
    int s0[$], s1[$];
    logic [3:0] modes [5] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010};

    always #5 iClock = ~iClock;

    stereo_decorrelator #(.DATA_W(W), .FIFO_DEPTH(8)) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iChanAssign(iChanAssign),
        .iBlockSize(iBlockSize), .iValid0(iValid0), .iSample0(iSample0), .oReady0(oReady0),
        .iValid1(iValid1), .iSample1(iSample1), .oReady1(oReady1), .oValid(oValid),
        .iReady(iReady), .oLeft(oLeft), .oRight(oRight), .oFrameDone(oFrameDone), .oError(oError)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] ca, input int a, input int b,
                                  output logic [15:0] l, output logic [15:0] r);
        int m, li, ri;
        m = 2 * a + (b & 1);
        li = a;
        ri = b;
        case (ca)
            4'b0000: ri = a;
            4'b1000: ri = a - b;
            4'b1001: li = a + b;
            4'b1010: begin li = (m + b) >>> 1; ri = (m - b) >>> 1; end
            default: ;
        endcase
        l = li[15:0];
        r = ri[15:0];
    endfunction

    task automatic fill_random(input int n);
        logic signed [15:0] t;
        logic signed [16:0] u;
        s0.delete();
        s1.delete();
        for (int i = 0; i < n; i++) begin
            t = 16'($urandom);
            u = 17'($urandom);
            s0.push_back(int'(t));
            s1.push_back(int'(u));
        end
    endtask

    task automatic do_start(input logic [3:0] ca, input int blk);
        @(negedge iClock);
        iStart = 1; iChanAssign = ca; iBlockSize = 16'(blk);
        iValid0 = 0; iValid1 = 0; iReady = 0;
        @(negedge iClock);
        iStart = 0;
    endtask

    task automatic run_frame(input logic [3:0] ca, input int blk, input int skew,
                             input int stall_at, input int stop_after);
        int n, i0, i1, acc, cyc;
        bit mono, stalled, have_h;
        logic [31:0] h;
        logic [15:0] el, er;
        n = (blk == 0) ? 1 : blk;
        i0 = 0; i1 = 0; acc = 0; cyc = 0; have_h = 0;
        mono = (ca == 4'b0000);
        do_start(ca, blk);
        while (acc < n && acc != stop_after && cyc < 2000) begin
            @(negedge iClock);
            cyc++;
            iValid0 = (i0 < n) && oReady0 && ($urandom_range(3) != 0);
            if (iValid0) begin iSample0 = 16'(s0[i0]); i0++; end
            iValid1 = !mono && (i1 < n) && oReady1 && (cyc > skew) && ($urandom_range(3) != 0);
            if (iValid1) begin iSample1 = 17'(s1[i1]); i1++; end
            stalled = (cyc >= stall_at) && (cyc < stall_at + 5);
            iReady = stalled ? 1'b0 : ($urandom_range(3) != 0);
            #1;
            if (skew > 0 && cyc == skew) begin
                check("skew_ready0", oReady0, 0);
                check("skew_valid", oValid, 0);
            end
            if (stalled && have_h) check("hold", {oValid, oLeft, oRight}, {1'b1, h});
            else if (stalled && oValid) begin h = {oLeft, oRight}; have_h = 1; end
            if (oValid && iReady) begin
                model(ca, s0[acc], s1[acc], el, er);
                check($sformatf("left[%0d]", acc), oLeft, el);
                check($sformatf("right[%0d]", acc), oRight, er);
                check($sformatf("done[%0d]", acc), oFrameDone, (acc == n - 1));
                acc++;
            end
        end
        if (acc < n && acc != stop_after) check("timeout_pairs", acc, n);
        else if (acc == n) begin
            @(negedge iClock);
            iValid0 = 0; iValid1 = 0; iReady = 0;
            #1;
            check("post_valid", oValid, 0);
            check("post_idle_ready", oReady0, 0);
            check("post_error", oError, 0);
        end
    endtask

    initial begin
        #22;
        check("rst_out", {oValid, oLeft, oRight, oFrameDone, oError, oReady0, oReady1}, 0);
        @(negedge iClock);
        iReset_n = 1;

        s0 = '{100, -5, 0, 32767};
        s1 = '{10, -10, 1, -1};
        run_frame(4'b1000, 4, 0, NOSTALL, -1);

        s0 = '{3, -2};
        s1 = '{1, -3};
        run_frame(4'b1010, 2, 0, NOSTALL, -1);

        fill_random(12);
        run_frame(4'b0001, 12, 40, NOSTALL, -1);

        fill_random(16);
        run_frame(4'b1010, 16, 0, 6, -1);

        do_start(4'b1011, 4);
        #1;
        check("err_flag", oError, 1);
        check("err_ready", {oReady0, oReady1}, 0);
        iValid0 = 1; iValid1 = 1; iReady = 1;
        repeat (3) @(negedge iClock);
        check("err_no_valid", oValid, 0);
        iValid0 = 0; iValid1 = 0; iReady = 0;
        fill_random(5);
        run_frame(4'b0001, 5, 0, NOSTALL, -1);

        fill_random(4);
        run_frame(4'b1000, 4, 0, NOSTALL, 3);
        @(negedge iClock);
        iValid0 = 0; iValid1 = 0; iReady = 0; iReset_n = 0;
        #1;
        check("midrst_out", {oValid, oLeft, oRight, oFrameDone, oError, oReady0, oReady1}, 0);
        @(negedge iClock);
        iReset_n = 1;

        for (int k = 0; k < 15; k++) begin
            logic [3:0] ca;
            int blk;
            ca = modes[$urandom_range(4)];
            blk = $urandom_range(0, 20);
            fill_random(blk == 0 ? 1 : blk);
            run_frame(ca, blk, 0, ($urandom_range(1) != 0) ? $urandom_range(2, 15) : NOSTALL, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
